// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, a 2-entry skid buffer,
// a synchronous flush, and NOP bubbles whenever the stage holds nothing.
module pipe_stage_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             accept;
  logic             pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // count is derived only from flops, so no input reaches it combinationally.
  assign count = {1'b0, out_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= NOP_VALUE;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_data   <= NOP_VALUE;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (!out_valid || (pop && !skid_valid)) begin
      if (accept) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_data  <= NOP_VALUE;
        out_valid <= 1'b0;
      end
    end else if (pop) begin
      // The skid entry moves up to main; in_ready was 0, so nothing new arrives.
      out_data   <= skid_data;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random-with-model bench for pipe_stage_reg (WIDTH=64, NOP_VALUE=0).
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic [1:0]  count;

  int n_chk;
  int n_pass;

  pipe_stage_reg #(.WIDTH(64), .NOP_VALUE(64'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .flush    (flush),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply inputs at a falling edge, let one rising edge consume them, and
  // return at the next falling edge so outputs can be sampled.
  task automatic step(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic [63:0] od,
                           input logic [1:0] cnt, input logic ir);
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ov});
    chk({tag, ".out_data"},  out_data, od);
    chk({tag, ".count"},     {62'd0, count}, {62'd0, cnt});
    chk({tag, ".in_ready"},  {63'd0, in_ready}, {63'd0, ir});
  endtask

  logic [63:0] q[$];
  logic        r_iv, r_fl, r_or, m_ready;
  logic [63:0] r_d;

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    flush = 1'b0;

    @(negedge clk);
    chk_state("reset_init", 1'b0, 64'h0, 2'd0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk_state("post_reset_idle", 1'b0, 64'h0, 2'd0, 1'b1);

    // Streaming: one word per cycle, one cycle of latency.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 64'(i), 1'b1, 1'b0);
      chk("stream.out_valid", {63'd0, out_valid}, 64'd1);
      chk("stream.out_data", out_data, 64'(i));
      chk("stream.in_ready", {63'd0, in_ready}, 64'd1);
    end

    // Bubbles: idle upstream drains to NOP.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 64'hFFFF, 1'b1, 1'b0);
      chk_state("bubble", 1'b0, 64'h0, 2'd0, 1'b1);
    end
    step(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    chk_state("after_bubble", 1'b1, 64'h0123_4567_89AB_CDEF, 2'd1, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk_state("after_bubble_drain", 1'b0, 64'h0, 2'd0, 1'b1);

    // Stall: A to main, B to skid, C held off, then drained in order.
    step(1'b1, 64'hA, 1'b0, 1'b0);
    chk_state("stall_A", 1'b1, 64'hA, 2'd1, 1'b1);
    step(1'b1, 64'hB, 1'b0, 1'b0);
    chk_state("stall_B", 1'b1, 64'hA, 2'd2, 1'b0);
    step(1'b1, 64'hC, 1'b0, 1'b0);
    chk_state("stall_C_held", 1'b1, 64'hA, 2'd2, 1'b0);
    step(1'b1, 64'hC, 1'b1, 1'b0);
    chk_state("release_B", 1'b1, 64'hB, 2'd1, 1'b1);
    step(1'b1, 64'hC, 1'b1, 1'b0);
    chk_state("release_C", 1'b1, 64'hC, 2'd1, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk_state("release_empty", 1'b0, 64'h0, 2'd0, 1'b1);

    // Flush with two held entries and an incoming word that must be squashed.
    step(1'b1, 64'hA, 1'b0, 1'b0);
    step(1'b1, 64'hB, 1'b0, 1'b0);
    chk_state("flush_pre", 1'b1, 64'hA, 2'd2, 1'b0);
    step(1'b1, 64'hD, 1'b0, 1'b1);
    chk_state("flush_post", 1'b0, 64'h0, 2'd0, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk_state("flush_no_D", 1'b0, 64'h0, 2'd0, 1'b1);

    // Async reset mid-cycle with count=2.
    step(1'b1, 64'h11, 1'b0, 1'b0);
    step(1'b1, 64'h22, 1'b0, 1'b0);
    chk_state("rst_pre", 1'b1, 64'h11, 2'd2, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_state("rst_async", 1'b0, 64'h0, 2'd0, 1'b1);
    @(negedge clk);
    chk_state("rst_hold", 1'b0, 64'h0, 2'd0, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Random traffic against a queue model.
    q.delete();
    r_iv = 1'b0;
    r_d = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      m_ready = (q.size() < 2);
      chk("rand.count", {62'd0, count}, 64'(q.size()));
      chk("rand.out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      chk("rand.out_data", out_data, (q.size() > 0) ? q[0] : 64'h0);
      chk("rand.in_ready", {63'd0, in_ready}, {63'd0, m_ready});
      // Upstream keeps a refused word on the bus until it is taken.
      if (!(r_iv && !m_ready)) begin
        r_iv = ($urandom_range(0, 99) < 70);
        r_d  = {$urandom, $urandom};
      end
      r_or = ($urandom_range(0, 99) < 60);
      r_fl = ($urandom_range(0, 99) < 5);
      if (r_fl) begin
        q.delete();
      end else begin
        if (r_or && q.size() > 0) void'(q.pop_front());
        if (r_iv && m_ready) q.push_back(r_d);
      end
      step(r_iv, r_d, r_or, r_fl);
      if (r_iv && m_ready) r_iv = 1'b0;
      if (r_fl) r_iv = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
